// File: rtl/nibble_add_seq_if.sv
// nibble_add_seq_if -- request/result bundle for the nibble-serial adder.
//
// Signals (W = 4*NIBBLES):
//   in_valid, a[W], b[W], cin   request from the producer
//   in_ready                    adder can take a request
//   busy                        adder is working on or holding a result
//   out_valid, sum[W], cout, zero
//                               result to the consumer
//   out_ready                   consumer takes the result
//
// master: the side that issues requests and consumes results.
// slave:  the adder itself.
interface nibble_add_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         zero;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, busy, out_valid, sum, cout, zero
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, busy, out_valid, sum, cout, zero
    );
endinterface

// File: rtl/nibble_add_seq.sv
// nibble_add_seq -- wide adder built from one 4-bit add slice, one nibble
// per clock, least-significant nibble first, carry rippled through a register.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   nibble_add_seq_if.slave
//           in_valid/in_ready      request handshake (a, b, cin sampled on accept)
//           out_valid/out_ready    result handshake (sum, cout, zero)
//           busy                   high while running or holding a result
//
// Accept on edge T -> out_valid after edge T+NIBBLES. The result stays on
// sum/cout/zero after it is consumed, until the next request is accepted.
module nibble_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    nibble_add_seq_if.slave  bus
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            carry_q;
    logic [IDXW-1:0] idx_q;
    logic [W-1:0]    sum_q;
    logic            cout_q;
    logic            zero_q;

    logic [3:0]      a_nib;
    logic [3:0]      b_nib;
    logic [4:0]      slice;
    logic [W-1:0]    sum_upd;
    logic            accept;
    logic            last;

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign accept = (state_q == IDLE) && bus.in_valid;
    assign last   = (idx_q == LAST_IDX);

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (last)          state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.busy      = (state_q != IDLE);
        bus.out_valid = (state_q == DONE);
    end

    // ----------------------------------------------------------- datapath
    // {idx, 2'b00} is 4*idx: the bit offset of the current nibble.
    assign a_nib = a_q[{idx_q, 2'b00} +: 4];
    assign b_nib = b_q[{idx_q, 2'b00} +: 4];
    assign slice = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};

    // Full sum including the nibble being written this cycle; zero is judged
    // on this so the final nibble counts.
    always_comb begin
        sum_upd = sum_q;
        sum_upd[{idx_q, 2'b00} +: 4] = slice[3:0];
    end

    // NOTE: the operand copies are reset too, so the whole datapath comes out
    // of reset in a known state and nothing depends on power-up contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            idx_q   <= '0;
            sum_q   <= '0;
        end else if (state_q == RUN) begin
            sum_q   <= sum_upd;
            carry_q <= slice[4];
            if (last) begin
                cout_q <= slice[4];
                zero_q <= (sum_upd == '0);
            end else begin
                idx_q  <= idx_q + 1'b1;
            end
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_nibble_add_seq.sv
// tb_nibble_add_seq -- directed bench for nibble_add_seq (NIBBLES = 4).
// The driver pushes the expected result into a queue when a request is
// accepted; an independent monitor pops and compares on each result handshake.
module tb_nibble_add_seq;
    localparam int N = 4;
    localparam int W = 4 * N;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    exp_t exp_q[$];

    nibble_add_seq_if #(.NIBBLES(N)) bus();

    nibble_add_seq #(.NIBBLES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Independent reference: plain wide addition.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] full;
        exp_t e;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.zero = (full[W-1:0] == '0);
        return e;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic z);
        exp_t e;
        e.sum = s; e.cout = c; e.zero = z;
        return e;
    endfunction

    // ------------------------------------------------------------ monitor
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL spurious_result: out_valid with sum %0h, expected no result", bus.sum);
            end else if (bus.out_ready) begin
                exp_t e;
                e = exp_q.pop_front();
                check("result_sum",  64'(bus.sum),  64'(e.sum));
                check("result_cout", 64'(bus.cout), 64'(e.cout));
                check("result_zero", 64'(bus.zero), 64'(e.zero));
            end
        end
    end

    // ------------------------------------------------------------- driver
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    endtask

    // Present a request, wait for acceptance, record the expected result.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input exp_t e, output int acc_cyc);
        bus.a = a; bus.b = b; bus.cin = cin; bus.in_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        acc_cyc = cyc;
        exp_q.push_back(e);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Result must appear exactly N edges after acceptance.
    task automatic wait_result(input string name);
        repeat (N - 1) begin
            tick();
            check({name, "_early"}, 64'(bus.out_valid), 64'd0);
        end
        tick();
        check({name, "_latency"}, 64'(bus.out_valid), 64'd1);
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("release_out_valid", 64'(bus.out_valid), 64'd0);
        check("release_in_ready",  64'(bus.in_ready),  64'd1);
    endtask

    int acc;
    int prev_acc;
    logic [W-1:0] ra, rb;
    logic         rc;

    initial begin
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_sum",       64'(bus.sum),       64'd0);
        check("rst_cout",      64'(bus.cout),      64'd0);
        check("rst_zero",      64'(bus.zero),      64'd0);

        // Basic add
        issue(16'h1234, 16'h4321, 1'b0, mk(16'h5555, 1'b0, 1'b0), acc);
        check("run_busy",     64'(bus.busy),     64'd1);
        check("run_in_ready", 64'(bus.in_ready), 64'd0);
        wait_result("basic");
        release_result();

        // Full carry ripple and a carry-in ripple
        issue(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b1), acc);
        wait_result("ripple");
        release_result();
        check("hold_after_done_sum",  64'(bus.sum),  64'h0000);
        check("hold_after_done_cout", 64'(bus.cout), 64'd1);
        issue(16'h00FF, 16'h0000, 1'b1, mk(16'h0100, 1'b0, 1'b0), acc);
        wait_result("cin_ripple");
        release_result();

        // Backpressure: DONE held for 5 cycles
        issue(16'h0F0F, 16'h1111, 1'b1, mk(16'h2021, 1'b0, 1'b0), acc);
        wait_result("bp");
        repeat (5) begin
            tick();
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_sum",       64'(bus.sum),       64'h2021);
            check("bp_in_ready",  64'(bus.in_ready),  64'd0);
        end
        release_result();

        // Busy rejection: second request presented during RUN with new operands
        issue(16'h1111, 16'h2222, 1'b0, mk(16'h3333, 1'b0, 1'b0), acc);
        bus.a = 16'hAAAA; bus.b = 16'h5555; bus.cin = 1'b0; bus.in_valid = 1'b1;
        wait_result("busy_first");
        check("busy_in_ready_done", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("busy_in_ready_back", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        exp_q.push_back(mk(16'hFFFF, 1'b0, 1'b0));
        #1;
        bus.in_valid = 1'b0;
        bus.a = 16'h0000; bus.b = 16'h0000;
        wait_result("busy_second");
        release_result();

        // Reset on the 2nd RUN cycle; the result is discarded, nothing pushed
        bus.a = 16'h1234; bus.b = 16'h4321; bus.cin = 1'b0; bus.in_valid = 1'b1;
        wait_ready();
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready",  64'(bus.in_ready),  64'd1);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_sum",       64'(bus.sum),       64'd0);
        check("midrst_busy",      64'(bus.busy),      64'd0);
        repeat (10) tick();
        check("midrst_no_result", 64'(bus.out_valid), 64'd0);

        // Back-to-back with out_ready tied high
        bus.out_ready = 1'b1;
        prev_acc = 0;
        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            if (i == 0) begin ra = 16'hFFFF; rb = 16'hFFFF; rc = 1'b1; end
            bus.a = ra; bus.b = rb; bus.cin = rc; bus.in_valid = 1'b1;
            wait_ready();
            @(posedge clk);
            acc = cyc;
            exp_q.push_back(model(ra, rb, rc));
            #1;
            if (i > 0) check("b2b_spacing", 64'(acc - prev_acc), 64'(N + 2));
            prev_acc = acc;
        end
        bus.in_valid = 1'b0;

        // Drain
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 50) begin
                tick();
                n++;
            end
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        bus.out_ready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/nibble_add_seq.md
Name: nibble_add_seq

Overview:
- Multi-cycle sequencer that adds two wide operands through a single 4-bit add slice, one nibble per clock, least-significant nibble first.
- Carry is propagated between nibbles.
- Provides the ALU path with an area-cheap wide adder.
- Valid/ready handshake on both the request side and the result side.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request present; a, b, cin are sampled when in_valid && in_ready
- in_ready  output  1  block can accept a request; high only in IDLE
- a  input  W  operand A
- b  input  W  operand B
- cin  input  1  carry into nibble 0
- busy  output  1  high in RUN or DONE
- out_valid  output  1  result available; high only in DONE
- out_ready  input  1  consumer accepts the result
- sum  output  W  a + b + cin, modulo 2^W
- cout  output  1  carry out of the top nibble
- zero  output  1  high when sum == 0

Behaviour:
- Clock and reset: single clock domain. rst is synchronous and active-high.
- Reset state:
  - state = IDLE, idx = 0, carry register = 0
  - sum = 0, cout = 0, zero = 0
  - out_valid = 0, busy = 0
  - in_ready = 1 on the first cycle after reset deasserts
- States: IDLE, RUN, DONE (registered FSM).
- IDLE:
  - in_ready = 1.
  - On an edge where in_valid = 1, latch a, b, cin into internal registers, clear sum, set idx = 0, go to RUN.
  - in_valid = 0 leaves the state unchanged.
- RUN (one nibble per cycle):
  - in_ready = 0, busy = 1.
  - Each edge computes the 5-bit value {c, s} = a[4*idx+3:4*idx] + b[4*idx+3:4*idx] + carry.
  - s is written to sum[4*idx+3:4*idx] and c to the carry register.
  - The carry register starts at the latched cin.
  - On the edge that processes idx = NIBBLES-1: cout <= c, zero <= (full sum == 0) including the nibble just written, go to DONE.
  - Otherwise idx increments by 1.
- DONE:
  - out_valid = 1.
  - sum, cout and zero are stable and held for as long as out_ready = 0.
  - On an edge where out_ready = 1, go to IDLE and drop out_valid.
  - sum, cout and zero keep their values after leaving DONE until the next acceptance.
- Latency: if the request is accepted on edge T, out_valid rises after edge T+NIBBLES. Throughput is one result per NIBBLES+2 cycles at best, because IDLE and DONE each take at least one cycle.
- No new request is accepted in the same cycle that a result is consumed; in_ready is combinationally (state == IDLE).
- in_valid while busy: ignored. Operands are not re-sampled, and the latched copies are used throughout RUN.
- Input changes on a, b or cin during RUN or DONE have no effect on the result.
- Reset during RUN or DONE: on the next edge the block returns to IDLE, clears all outputs and discards the result. No out_valid pulse is produced.
- NIBBLES = 1: RUN lasts exactly one cycle.
- Width rules:
  - All arithmetic is unsigned; overflow is reported only through cout.
  - The idx counter is wide enough for NIBBLES-1 (clog2, minimum 1 bit) and never wraps past NIBBLES-1.

Test Plan (NIBBLES = 4):
- Basic add: accept a=16'h1234, b=16'h4321, cin=0 -> out_valid exactly 4 cycles after acceptance; sum=16'h5555, cout=0, zero=0.
- Full carry ripple: a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, zero=1. Also a=16'h00FF, b=16'h0000, cin=1 -> sum=16'h0100, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and sum stay constant; in_ready=0 throughout; one cycle after out_ready=1, in_ready=1.
- Busy rejection: present a second request (a=16'hAAAA, b=16'h5555) during RUN and change a/b mid-run -> first result is unaffected; the second request is accepted only once in_ready returns to 1, and yields sum=16'hFFFF, cout=0.
- Reset mid-operation: assert rst on the 2nd RUN cycle -> next cycle state is IDLE, out_valid=0, sum=0, in_ready=1; no spurious result afterwards.
- Back-to-back: 8 random requests with out_ready tied high, compared against a reference model -> every sum/cout matches, and acceptance spacing is NIBBLES+2 cycles.
